// File: rtl/sqrt_pkg.sv
// Parameters and status-bit indices shared by the square-root datapath and its control path.
package sqrt_pkg;

  localparam int X_W_DEF = 8;

  // N_o bit positions, so the control path never hard-codes them.
  localparam int N_DONE  = 1;
  localparam int N_EXACT = 0;

  // The root is half the radicand width.
  function automatic int sqrt_root_w(input int x_w);
    return x_w / 2;
  endfunction

endpackage

// File: rtl/sqrt_step_adder.sv
// Single shared adder of the square-root datapath: one increment per step,
// selecting either the square update or the root update.
module sqrt_step_adder
  import sqrt_pkg::*;
#(
  parameter int X_W = X_W_DEF,
  parameter int R_W = sqrt_root_w(X_W)
) (
  input  logic           muxes_i,
  input  logic [R_W-1:0] root_q,
  input  logic [X_W:0]   square_q,
  output logic [X_W:0]   add_o
);

  localparam logic [X_W:0] ONE   = (X_W+1)'(1);
  localparam logic [X_W:0] THREE = (X_W+1)'(3);

  logic [X_W:0] root_ext;

  assign root_ext = {{(X_W + 1 - R_W){1'b0}}, root_q};

  // (r+2)^2 = (r+1)^2 + 2r + 3, so the square step walks to the next perfect square.
  // NOTE: always_comb gives add_o a value on every path, so no latch can be inferred.
  always_comb begin
    add_o = root_ext + ONE;
    if (muxes_i) begin
      add_o = square_q + (root_ext << 1) + THREE;
    end
  end

endmodule

// File: rtl/sqrt_datapath.sv
// Integer square-root datapath: holds radicand, running root and (root+1)^2,
// and reports loop-done / exact-square status to an external control path.
module sqrt_datapath
  import sqrt_pkg::*;
#(
  parameter  int X_W = X_W_DEF,
  localparam int R_W = sqrt_root_w(X_W)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [X_W-1:0] x_i,
  input  logic           boot_i,
  input  logic           muxes_i,
  input  logic           wr_root_i,
  input  logic           wr_square_i,
  input  logic           root_i,
  output logic [1:0]     N_o,
  output logic [R_W-1:0] result_o,
  output logic           valid_o,
  output logic           ovf_o
);

  logic [X_W-1:0] x_q;
  logic [R_W-1:0] root_q;
  logic [X_W:0]   square_q;
  logic [X_W:0]   add;
  logic           square_live;

  sqrt_step_adder #(
    .X_W (X_W),
    .R_W (R_W)
  ) u_step_adder (
    .muxes_i  (muxes_i),
    .root_q   (root_q),
    .square_q (square_q),
    .add_o    (add)
  );

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q      <= '0;
      root_q   <= '0;
      square_q <= '0;
      result_o <= '0;
      valid_o  <= 1'b0;
      ovf_o    <= 1'b0;
    end else if (boot_i) begin
      x_q      <= x_i;
      root_q   <= '0;
      square_q <= (X_W+1)'(1);
      valid_o  <= 1'b0;
      ovf_o    <= 1'b0;
    end else begin
      if (wr_square_i) begin
        square_q <= add;
      end
      // A root step at the maximum root saturates instead of wrapping to zero.
      if (wr_root_i) begin
        if (&root_q) begin
          ovf_o <= 1'b1;
        end else begin
          root_q <= add[R_W-1:0];
        end
      end
      if (root_i) begin
        result_o <= root_q;
        valid_o  <= 1'b1;
      end
    end
  end

  // square_q is never zero once booted, so zero marks the reset state and masks both flags.
  assign square_live     = |square_q;
  assign N_o[N_DONE]     = square_live && (square_q > {1'b0, x_q});
  assign N_o[N_EXACT]    = square_live && (square_q == {1'b0, x_q});

endmodule

// File: tb/tb_sqrt_datapath.sv
// Directed-vector bench for sqrt_datapath with hand-computed expected values.
module tb_sqrt_datapath;
  import sqrt_pkg::*;

  localparam int X_W = 8;
  localparam int R_W = 4;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [X_W-1:0] x_i = '0;
  logic           boot_i = 1'b0;
  logic           muxes_i = 1'b0;
  logic           wr_root_i = 1'b0;
  logic           wr_square_i = 1'b0;
  logic           root_i = 1'b0;
  logic [1:0]     N_o;
  logic [R_W-1:0] result_o;
  logic           valid_o;
  logic           ovf_o;

  int vectors = 0;
  int miscompares = 0;

  sqrt_datapath #(.X_W(X_W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .x_i         (x_i),
    .boot_i      (boot_i),
    .muxes_i     (muxes_i),
    .wr_root_i   (wr_root_i),
    .wr_square_i (wr_square_i),
    .root_i      (root_i),
    .N_o         (N_o),
    .result_o    (result_o),
    .valid_o     (valid_o),
    .ovf_o       (ovf_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Drive one cycle of controls at the falling edge, release them just after the rising edge.
  task automatic cycle(input logic b, input logic m, input logic wr, input logic ws, input logic rt);
    @(negedge clk);
    boot_i = b; muxes_i = m; wr_root_i = wr; wr_square_i = ws; root_i = rt;
    @(posedge clk);
    #1;
    boot_i = 1'b0; muxes_i = 1'b0; wr_root_i = 1'b0; wr_square_i = 1'b0; root_i = 1'b0;
  endtask

  task automatic do_boot(input logic [X_W-1:0] x);
    x_i = x;
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic do_pair();
    cycle(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic do_capture();
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  // Iterate like the control path would, bounded so a stuck done flag cannot hang the run.
  task automatic run_to_done(input string tag, input int exp_pairs);
    int n = 0;
    while (!N_o[N_DONE] && n < 64) begin
      do_pair();
      n++;
    end
    check(tag, n, exp_pairs);
  endtask

  initial begin
    // Reset state
    #12;
    check("rst_N_o", N_o, 2'b00);
    check("rst_result", result_o, 0);
    check("rst_valid", valid_o, 0);
    check("rst_ovf", ovf_o, 0);
    check("rst_root", dut.root_q, 0);
    check("rst_square", dut.square_q, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // x = 0
    do_boot(8'd0);
    check("x0_root", dut.root_q, 0);
    check("x0_square", dut.square_q, 1);
    check("x0_N_o", N_o, 2'b10);
    do_capture();
    check("x0_result", result_o, 0);
    check("x0_valid", valid_o, 1);

    // x = 16: square walks 1,4,9,16,25
    do_boot(8'd16);
    check("x16_valid_cleared", valid_o, 0);
    check("x16_square0", dut.square_q, 1);
    for (int i = 1; i <= 4; i++) begin
      do_pair();
      check($sformatf("x16_square%0d", i), dut.square_q, (i + 1) * (i + 1));
      if (i == 3) check("x16_exact", N_o, 2'b01);
    end
    check("x16_N_o_done", N_o, 2'b10);
    check("x16_root", dut.root_q, 4);
    do_capture();
    check("x16_result", result_o, 4);

    // x = 255: maximum root, then saturation
    do_boot(8'd255);
    run_to_done("x255_pairs", 15);
    check("x255_done", N_o[N_DONE], 1);
    do_capture();
    check("x255_result", result_o, 15);
    check("x255_ovf", ovf_o, 0);
    cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    check("sat_root", dut.root_q, 15);
    check("sat_ovf", ovf_o, 1);

    // x = 15: boot clears the sticky overflow
    do_boot(8'd15);
    check("x15_ovf_cleared", ovf_o, 0);
    run_to_done("x15_pairs", 3);
    do_capture();
    check("x15_result", result_o, 3);

    // x = 200: asynchronous reset between edges mid-iteration
    do_boot(8'd200);
    for (int i = 0; i < 5; i++) do_pair();
    check("x200_mid_root", dut.root_q, 5);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_root", dut.root_q, 0);
    check("arst_square", dut.square_q, 0);
    check("arst_x", dut.x_q, 0);
    check("arst_result", result_o, 0);
    check("arst_valid", valid_o, 0);
    check("arst_N_o", N_o, 2'b00);
    @(negedge clk);
    rst_n = 1'b1;
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("idle_after_rst_N_o", N_o, 2'b00);
    check("idle_after_rst_valid", valid_o, 0);
    do_boot(8'd200);
    run_to_done("x200_pairs", 14);
    do_capture();
    check("x200_result", result_o, 14);

    // No enables: everything holds
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    check("hold_root", dut.root_q, 14);
    check("hold_square", dut.square_q, 225);
    check("hold_valid", valid_o, 1);

    // Boot overrides every write enable and the capture
    x_i = 8'd9;
    cycle(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    check("bootpri_root", dut.root_q, 0);
    check("bootpri_square", dut.square_q, 1);
    check("bootpri_x", dut.x_q, 9);
    check("bootpri_valid", valid_o, 0);
    check("bootpri_result", result_o, 14);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
